// File: rtl/mul_div_unit_pkg.sv
// Shared opcode encodings, FSM states and helpers for the HI/LO multiply/divide unit.
package mul_div_unit_pkg;

  localparam int XLEN_DEF = 32;

  // One-hot mul_control encodings from the R-type decode.
  localparam logic [3:0] MULT_MC  = 4'b0001;
  localparam logic [3:0] MULTU_MC = 4'b0010;
  localparam logic [3:0] DIV_MC   = 4'b0100;
  localparam logic [3:0] DIVU_MC  = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_t;

  // Only the four defined encodings start an operation.
  function automatic logic is_valid_mc(input logic [3:0] mc);
    return (mc == MULT_MC) || (mc == MULTU_MC) || (mc == DIV_MC) || (mc == DIVU_MC);
  endfunction

  // mult and div interpret operands as two's complement; multu/divu do not.
  function automatic logic is_signed_mc(input logic [3:0] mc);
    return (mc == MULT_MC) || (mc == DIV_MC);
  endfunction

  function automatic logic is_div_mc(input logic [3:0] mc);
    return (mc == DIV_MC) || (mc == DIVU_MC);
  endfunction

endpackage

// File: rtl/mdu_datapath.sv
// Shared shift register and XLEN+1-bit adder/subtractor for the iterative multiply/divide.
// Multiply: acc = {partial product, multiplier}, one multiplier bit consumed per step.
// Divide:   acc = {remainder, dividend/quotient}, one quotient bit produced per step.
module mdu_datapath #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              mode_div,
  input  logic [XLEN-1:0]   load_lo,
  input  logic [XLEN-1:0]   load_m,
  output logic [2*XLEN-1:0] acc
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   m_q, m_d;
  logic [XLEN:0]     op_x, op_y, sum;
  logic              cin;
  logic              q_bit;

  // One shared adder: add-if-bit-set for multiply, trial subtract for divide.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
    acc_d = acc_q;
    m_d   = m_q;
    op_x  = {1'b0, acc_q[2*XLEN-1:XLEN]};
    op_y  = '0;
    cin   = 1'b0;
    if (mode_div) begin
      op_x = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      op_y = ~{1'b0, m_q};
      cin  = 1'b1;
    end else if (acc_q[0]) begin
      op_y = {1'b0, m_q};
    end
    sum   = op_x + op_y + {{XLEN{1'b0}}, cin};
    // No borrow out of the trial subtract means the shifted remainder >= divisor.
    q_bit = ~sum[XLEN];
    if (load) begin
      acc_d = {{XLEN{1'b0}}, load_lo};
      m_d   = load_m;
    end else if (step) begin
      if (mode_div) begin
        acc_d = {(q_bit ? sum[XLEN-1:0] : op_x[XLEN-1:0]), acc_q[XLEN-2:0], q_bit};
      end else begin
        acc_d = {sum, acc_q[XLEN-1:1]};
      end
    end
  end

  // Shift register and operand register update.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      acc_q <= '0;
      m_q   <= '0;
    end else begin
      acc_q <= acc_d;
      m_q   <= m_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: FSM, iteration counter, sign handling and HI/LO registers.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [3:0]      mul_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic            cancel,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   hi_q, lo_q;
  logic              done_q;
  logic              is_div_q, neg_res_q, neg_rem_q, div_zero_q;

  logic              op_signed, op_div, start_ok;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [2*XLEN-1:0] dp_acc, prod_fix;
  logic [XLEN-1:0]   quo, rem, quo_fix, rem_fix, res_hi, res_lo;

  // Operand decode and magnitude extraction for the accept cycle.
  assign op_signed = is_signed_mc(mul_control);
  assign op_div    = is_div_mc(mul_control);
  assign sign_a    = op_signed & src_a[XLEN-1];
  assign sign_b    = op_signed & src_b[XLEN-1];
  assign a_abs     = sign_a ? -src_a : src_a;
  assign b_abs     = sign_b ? -src_b : src_b;
  // A flush in the same cycle vetoes the start.
  assign start_ok  = (state_q == ST_IDLE) && start_valid && !cancel && is_valid_mc(mul_control);

  mdu_datapath #(.XLEN(XLEN)) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load     (start_ok),
    .step     ((state_q == ST_MUL) || (state_q == ST_DIV)),
    .mode_div (state_q == ST_DIV),
    .load_lo  (op_div ? a_abs : b_abs),
    .load_m   (op_div ? b_abs : a_abs),
    .acc      (dp_acc)
  );

  // Signed fix-up of the unsigned magnitude result; divide by zero forces an all-ones quotient.
  assign prod_fix = neg_res_q ? -dp_acc : dp_acc;
  assign quo      = dp_acc[XLEN-1:0];
  assign rem      = dp_acc[2*XLEN-1:XLEN];
  assign quo_fix  = div_zero_q ? '1 : (neg_res_q ? -quo : quo);
  assign rem_fix  = neg_rem_q ? -rem : rem;
  assign res_hi   = is_div_q ? rem_fix : prod_fix[2*XLEN-1:XLEN];
  assign res_lo   = is_div_q ? quo_fix : prod_fix[XLEN-1:0];

  // Control FSM plus HI/LO ownership.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            cnt_q      <= '0;
            is_div_q   <= op_div;
            neg_res_q  <= sign_a ^ sign_b;
            neg_rem_q  <= sign_a;
            div_zero_q <= op_div && (src_b == '0);
            state_q    <= op_div ? ST_DIV : ST_MUL;
          end else if (!start_valid) begin
            if (mthi) hi_q <= src_a;
            if (mtlo) lo_q <= src_a;
          end
        end
        ST_MUL, ST_DIV: begin
          if (cancel) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN - 1)) state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (cancel) begin
            state_q <= ST_IDLE;
          end else begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign start_ready = (state_q == ST_IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

  // HI/LO moves that the unit drops are flagged in simulation.
  a_mt_while_busy : assert property (@(posedge clk) disable iff (rst)
    !(busy && (mthi || mtlo)))
    else $warning("mthi/mtlo dropped: unit busy");
  a_mt_with_start : assert property (@(posedge clk) disable iff (rst)
    !(!busy && start_valid && (mthi || mtlo)))
    else $warning("mthi/mtlo dropped: start presented in the same cycle");

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected HI/LO, a monitor pops on done.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int XLEN    = 32;
  localparam int LATENCY = XLEN + 2;  // accept cycle to done cycle

  logic            clk = 1'b0;
  logic            rst, start_valid, mthi, mtlo, cancel;
  logic [3:0]      mc;
  logic [XLEN-1:0] src_a, src_b;
  logic            start_ready, busy, done;
  logic [XLEN-1:0] hi, lo;

  mul_div_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .mul_control (mc),
    .src_a       (src_a),
    .src_b       (src_b),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .cancel      (cancel),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result from plain signed/unsigned arithmetic; returns {hi, lo}.
  function automatic logic [63:0] ref_model(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb, q, r;
    logic [63:0] p;
    sa = a;
    sb = b;
    case (m)
      MULT_MC:  p = longint'(sa) * longint'(sb);
      MULTU_MC: p = {32'h0, a} * {32'h0, b};
      DIV_MC: begin
        if (b == 0)                                   p = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == '1)       p = {32'h0, 32'h8000_0000};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r, q};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else        p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no completion pending");
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_hi"}, hi, mon_e.hi);
        check({mon_e.name, "_lo"}, lo, mon_e.lo);
        check({mon_e.name, "_latency"}, cyc - mon_e.cyc, LATENCY);
        model_hi = mon_e.hi;
        model_lo = mon_e.lo;
      end
    end
  end

  // Called at a negedge; presents the op once the unit is ready and records the expected result.
  task automatic issue(input string name, input logic [3:0] m, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_done, input logic [63:0] exp_res);
    int waited = 0;
    while (start_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (start_ready !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_ready_timeout: got start_ready=%b expected 1", name, start_ready);
      return;
    end
    start_valid = 1'b1;
    mc          = m;
    src_a       = a;
    src_b       = b;
    if (expect_done) exp_q.push_back('{name, exp_res[63:32], exp_res[31:0], cyc});
    @(negedge clk);
    start_valid = 1'b0;
    mc          = 4'($urandom);
    src_a       = $urandom;
    src_b       = $urandom;
  endtask

  task automatic issue_ref(input string name, input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
    issue(name, m, a, b, 1'b1, ref_model(m, a, b));
  endtask

  task automatic wait_idle();
    int waited = 0;
    while ((exp_q.size() != 0 || start_ready !== 1'b1) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0 || start_ready !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: got %0d pending, start_ready=%b expected 0 pending, 1", exp_q.size(), start_ready);
      exp_q.delete();
    end
  endtask

  // Called at a negedge while idle.
  task automatic mt_write(input bit h, input bit l, input logic [31:0] v);
    mthi  = h;
    mtlo  = l;
    src_a = v;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    if (h) model_hi = v;
    if (l) model_lo = v;
    check("mt_hi", hi, model_hi);
    check("mt_lo", lo, model_lo);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0] ops[4];
    ops = '{MULT_MC, MULTU_MC, DIV_MC, DIVU_MC};
    rst = 1'b1; start_valid = 1'b0; mthi = 1'b0; mtlo = 1'b0; cancel = 1'b0;
    mc = '0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_ready", start_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Zero and multi-hot controls must not start anything.
    start_valid = 1'b1; mc = 4'b0000; src_a = 32'd9; src_b = 32'd3;
    @(negedge clk);
    check("mc_zero_busy", busy, 1'b0);
    mc = 4'b0011;
    @(negedge clk);
    check("mc_multihot_busy", busy, 1'b0);
    start_valid = 1'b0;

    // Directed vectors, issued back to back as soon as ready returns.
    issue("multu_max",  MULTU_MC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
    issue("mult_m3x7",  MULT_MC,  32'hFFFF_FFFD, 32'd7,         1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    issue("divu_100_7", DIVU_MC,  32'd100,       32'd7,         1'b1, 64'h0000_0002_0000_000E);
    issue("div_m7_2",   DIV_MC,   32'hFFFF_FFF9, 32'd2,         1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
    issue("div_ovf",    DIV_MC,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000);
    issue("divu_5_0",   DIVU_MC,  32'd5,         32'd0,         1'b1, 64'h0000_0005_FFFF_FFFF);
    issue("div_m5_0",   DIV_MC,   32'hFFFF_FFFB, 32'd0,         1'b1, 64'hFFFF_FFFB_FFFF_FFFF);
    issue("div_7_m2",   DIV_MC,   32'd7,         32'hFFFF_FFFE, 1'b1, 64'h0000_0001_FFFF_FFFD);
    issue("mult_min2",  MULT_MC,  32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    wait_idle();

    // HI/LO moves in idle.
    mt_write(1'b1, 1'b0, 32'h0000_1234);
    mt_write(1'b0, 1'b1, 32'h0000_5678);
    mt_write(1'b1, 1'b1, 32'hCAFE_F00D);

    // mthi while busy is ignored; HI holds its previous value until the op commits.
    issue_ref("divu_busy", DIVU_MC, 32'd1000, 32'd3);
    repeat (3) @(negedge clk);
    mthi = 1'b1; src_a = 32'hDEAD_BEEF;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_busy_hi", hi, model_hi);
    wait_idle();

    // Cancel at cycle 10 of a divide: back to idle next cycle, HI/LO untouched, no done.
    issue("div_cancel", DIV_MC, 32'd12345, 32'd67, 1'b0, 64'h0);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_ready", start_ready, 1'b1);
    check("cancel_hi", hi, model_hi);
    check("cancel_lo", lo, model_lo);
    repeat (40) @(negedge clk);

    // Start presented together with cancel in idle is not accepted.
    start_valid = 1'b1; mc = MULT_MC; cancel = 1'b1;
    @(negedge clk);
    start_valid = 1'b0; cancel = 1'b0;
    check("cancel_start_busy", busy, 1'b0);

    // Reset in the middle of a multiply discards it and clears HI/LO.
    issue("mult_rst", MULT_MC, 32'd77, 32'd99, 1'b0, 64'h0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_hi = '0;
    model_lo = '0;
    check("rst_mid_hi", hi, 32'h0);
    check("rst_mid_lo", lo, 32'h0);
    check("rst_mid_ready", start_ready, 1'b1);
    repeat (40) @(negedge clk);

    // Randomised ops against the arithmetic reference, with occasional HI/LO moves.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        wait_idle();
        mt_write(1'($urandom), 1'($urandom), $urandom);
      end
      issue_ref($sformatf("rand%0d", i), ops[$urandom_range(0, 3)], pick_operand(), pick_operand());
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
